// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writes a program into instruction memory. The program arrives as a byte
// stream over a valid/ready handshake. The first byte is the word count N.
// It is followed by N little-endian 32-bit words. Each word is written to
// byte addresses 0, 4, 8, ... The CPU is held in reset (cpu_rst_n=0) until a
// complete image has been written.
//
// Optional feature (compile-time macro LOADER_CHECKSUM_EN):
//   After the last word (or straight after a zero header), one extra byte is
//   consumed. It must equal the XOR of the header byte and all data bytes.
//   On a mismatch the loader goes to ERROR and the CPU stays in reset.
//
// Parameters:
//   ADDR_W     width of the instruction-memory byte address
//   MAX_WORDS  largest accepted program size in words (<= 2**ADDR_W / 4)
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   byte_valid   a byte is offered on byte_data
//   byte_data    stream byte
//   byte_ready   loader accepts byte_data this cycle
//   mem_we       instruction-memory write strobe, one cycle per word
//   mem_addr     byte address of the word being written
//   mem_wdata    word being written
//   cpu_rst_n    active-low CPU reset
//   busy         a load is in progress
//   done         last load completed successfully
//   error        last load was rejected
//   word_count   words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        DONE,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        ERROR
    } state_t;

    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [23:0] asm_word;   // lanes 0..2; lane 3 comes straight from byte_data
    logic [7:0]  n_words;
    logic [7:0]  wc_inc;
    logic        fire;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Byte address of a word index, truncated to the memory address width.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [7:0] idx);
        logic [ADDR_W+9:0] full;
        full = {{ADDR_W{1'b0}}, idx, 2'b00};
        return full[ADDR_W-1:0];
    endfunction

    assign fire   = byte_valid && byte_ready;
    assign wc_inc = word_count + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_rst_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = HDR;
            end
            HDR: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (fire) begin
                    if (byte_data == 8'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end else if ({1'b0, byte_data} > MAX_N) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (fire && byte_idx == 2'd3) state_next = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (wc_inc == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (fire) state_next = (byte_data == csum) ? DONE : ERROR;
            end
`endif
            DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
                if (start) state_next = HDR;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = HDR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: header capture, byte assembly, write address/data, counter.
    // mem_addr/mem_wdata are loaded on the 4th byte so they are valid during
    // the WRITE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            asm_word   <= '0;
            n_words    <= 8'd0;
            word_count <= 8'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) word_count <= 8'd0;
                end
                HDR: begin
                    if (fire) begin
                        n_words  <= byte_data;
                        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= byte_data;
`endif
                    end
                end
                DATA: begin
                    if (fire) begin
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        case (byte_idx)
                            2'd0: asm_word[7:0]   <= byte_data;
                            2'd1: asm_word[15:8]  <= byte_data;
                            2'd2: asm_word[23:16] <= byte_data;
                            default: begin
                                mem_wdata <= {byte_data, asm_word};
                                mem_addr  <= word_addr(word_count);
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_count <= wc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader: directed, table-driven bench for imem_loader. Each table
// entry describes one load (header, words, byte gap) and the expected final
// status. Hand-written sequences cover reset, restart from DONE, reset
// mid-load and (when LOADER_CHECKSUM_EN is defined) the checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;
    logic [7:0]        word_count;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle.
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                wcy_q[$];
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
            wcy_q.push_back(cyc);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        wcy_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte until accepted (bounded), then idle for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = -1;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (byte_ready) ok = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        if (ok) acc_cyc = cyc;
        else check("byte_accept_timeout", 32'd0, 32'd1);
        repeat (gap) tick();
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) check("busy_timeout", 32'd1, 32'd0);
    endtask

    typedef struct packed {
        logic [7:0]       n;
        logic [7:0]       nw;      // words actually sent and expected written
        logic [2:0][31:0] w;
        logic [7:0]       gap;
        logic             exp_done;
        logic             exp_err;
        logic [7:0]       exp_wc;
    } vec_t;

    function automatic vec_t mkvec(input logic [7:0] n, input logic [7:0] nw,
                                   input logic [31:0] w0, input logic [31:0] w1,
                                   input logic [31:0] w2, input logic [7:0] gap,
                                   input logic d, input logic e, input logic [7:0] wc);
        vec_t v;
        v.n = n; v.nw = nw; v.gap = gap;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.exp_done = d; v.exp_err = e; v.exp_wc = wc;
        return v;
    endfunction

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        logic [7:0]  cs;
        logic [31:0] word;
        int acc_q[$];
        logic [31:0] exp_w;

        vecs[0] = mkvec(8'h01, 8'd1, 32'h00500513, 32'h0, 32'h0, 8'd0, 1'b1, 1'b0, 8'd1);
        vecs[1] = mkvec(8'h03, 8'd3, 32'h00000093, 32'h00100113, 32'h002081B3, 8'd2, 1'b1, 1'b0, 8'd3);
        vecs[2] = mkvec(8'h41, 8'd0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b0, 1'b1, 8'd0);
        vecs[3] = mkvec(8'h00, 8'd0, 32'h0, 32'h0, 32'h0, 8'd0, 1'b1, 1'b0, 8'd0);
        vecs[4] = mkvec(8'h02, 8'd2, 32'hDEADBEEF, 32'h12345678, 32'h0, 8'd1, 1'b1, 1'b0, 8'd2);

        // Reset values
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_word_count", word_count, 0);
        tick();

        // Table-driven loads
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            acc_q.delete();
            pulse_start();
            @(negedge clk);
            check($sformatf("v%0d_busy_in_hdr", v), busy, 1);
            check($sformatf("v%0d_cpu_held", v), cpu_rst_n, 0);
            tick();
            cs = vecs[v].n;
            send_byte(vecs[v].n, vecs[v].gap, ac);
            for (int k = 0; k < 3; k++) begin
                if (k < int'(vecs[v].nw)) begin
                    word = vecs[v].w[k];
                    for (int b = 0; b < 4; b++) begin
                        cs = cs ^ word[8*b +: 8];
                        send_byte(word[8*b +: 8], vecs[v].gap, ac);
                    end
                    acc_q.push_back(ac);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            if (!vecs[v].exp_err) send_byte(cs, 0, ac);
`endif
            wait_idle();
            check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
            check($sformatf("v%0d_error", v), error, vecs[v].exp_err);
            check($sformatf("v%0d_cpu_rst_n", v), cpu_rst_n, vecs[v].exp_done);
            check($sformatf("v%0d_byte_ready", v), byte_ready, 0);
            check($sformatf("v%0d_word_count", v), word_count, vecs[v].exp_wc);
            check($sformatf("v%0d_nwrites", v), wa_q.size(), vecs[v].nw);
            for (int k = 0; k < int'(vecs[v].nw) && k < wa_q.size(); k++) begin
                exp_w = vecs[v].w[k];
                check($sformatf("v%0d_addr%0d", v, k), wa_q[k], k * 4);
                check($sformatf("v%0d_data%0d", v, k), wd_q[k], exp_w);
                check($sformatf("v%0d_latency%0d", v, k), wcy_q[k], acc_q[k]);
            end
        end

        // Restart from DONE: CPU reset drops the cycle after start
        clear_mon();
        check("rs_cpu_running", cpu_rst_n, 1);
        pulse_start();
        @(negedge clk);
        check("rs_cpu_rst_n_drop", cpu_rst_n, 0);
        check("rs_done_cleared", done, 0);
        check("rs_word_count_cleared", word_count, 0);
        tick();
        send_byte(8'h01, 0, ac);
        send_byte(8'hEF, 0, ac);
        send_byte(8'hBE, 0, ac);
        send_byte(8'hAD, 0, ac);
        send_byte(8'hDE, 0, ac);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 0, ac);
`endif
        wait_idle();
        check("rs_nwrites", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            check("rs_addr", wa_q[0], 0);
            check("rs_data", wd_q[0], 32'hDEADBEEF);
        end
        check("rs_done", done, 1);

        // Reset mid-load: 6 of 8 data bytes, then 1-cycle reset
        clear_mon();
        pulse_start();
        send_byte(8'h02, 0, ac);
        for (int b = 0; b < 6; b++) send_byte(8'h10 + 8'(b), 0, ac);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_nwrites", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            check("mr_addr", wa_q[0], 0);
            check("mr_data", wd_q[0], 32'h13121110);
        end
        check("mr_byte_ready", byte_ready, 0);
        check("mr_cpu_rst_n", cpu_rst_n, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_error", error, 0);
        check("mr_word_count", word_count, 0);
        check("mr_mem_addr", mem_addr, 0);
        check("mr_mem_wdata", mem_wdata, 0);
        tick();
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mr_not_accepted%0d", i), byte_ready, 0);
            tick();
        end
        byte_valid = 1'b0;
        check("mr_no_extra_writes", wa_q.size(), 1);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        clear_mon();
        pulse_start();
        send_byte(8'h01, 0, ac);
        send_byte(8'h13, 0, ac);
        send_byte(8'h05, 0, ac);
        send_byte(8'h50, 0, ac);
        send_byte(8'h00, 0, ac);
        send_byte(8'h47, 0, ac);
        wait_idle();
        check("ck_good_done", done, 1);
        check("ck_good_cpu", cpu_rst_n, 1);
        clear_mon();
        pulse_start();
        send_byte(8'h01, 0, ac);
        send_byte(8'h13, 0, ac);
        send_byte(8'h05, 0, ac);
        send_byte(8'h50, 0, ac);
        send_byte(8'h00, 0, ac);
        send_byte(8'h00, 0, ac);
        wait_idle();
        check("ck_bad_error", error, 1);
        check("ck_bad_done", done, 0);
        check("ck_bad_cpu", cpu_rst_n, 0);
        check("ck_bad_nwrites", wa_q.size(), 1);
        if (wd_q.size() > 0) check("ck_bad_data", wd_q[0], 32'h00500513);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. It receives a program as a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit words.
- It writes each word into instruction memory at consecutive byte addresses 0, 4, 8, ...
- It holds the CPU (PC register) in reset until the load completes, so the core starts fetching from address 0 only once a valid image is in place.

Parameters:
- ADDR_W, 8, width of the instruction-memory byte address.
- MAX_WORDS, 64, largest accepted program size in words; must be <= 2**ADDR_W / 4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  in  1  a byte is offered on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle; a transfer happens when byte_valid && byte_ready.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  byte address of the word being written (word index * 4).
- mem_wdata  out  32  word being written.
- cpu_rst_n  out  1  active-low CPU reset; drives the PC reset input.
- busy  out  1  a load is in progress (HDR, DATA, WRITE).
- done  out  1  last load completed successfully.
- error  out  1  last load was rejected.
- word_count  out  8  number of words written in the current or last load.

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0, word_count=0. FSM goes to IDLE, the byte shift register clears, and the target count N clears.
- States: IDLE, HDR, DATA, WRITE, DONE, ERROR.
- IDLE: cpu_rst_n=0, byte_ready=0. On start: go to HDR and clear word_count, done and error.
- HDR: byte_ready=1. The first accepted byte is N.
  - N=0: go to DONE.
  - N>MAX_WORDS: go to ERROR.
  - Otherwise: go to DATA with byte index 0.
- DATA: byte_ready=1.
  - Each accepted byte goes into lane byte_idx of the assembly register. Byte 0 lands in bits [7:0], byte 3 in bits [31:24].
  - When the 4th byte is accepted: go to WRITE.
- WRITE: exactly one cycle.
  - mem_we=1, byte_ready=0.
  - mem_wdata = the assembled word.
  - mem_addr = word_count << 2, truncated to ADDR_W.
  - At the end of the cycle word_count increments. If the new word_count equals N, go to DONE (or to CHK with LOADER_CHECKSUM_EN); otherwise return to DATA.
- Timing: write latency from acceptance of the 4th byte to mem_we is exactly 1 cycle. Max throughput is 4 bytes per 5 cycles.
- DONE: done=1, cpu_rst_n=1 (CPU runs), byte_ready=0. On start: restart at HDR, and cpu_rst_n drops to 0 in the cycle after start.
- ERROR: error=1, cpu_rst_n=0, byte_ready=0. Only start or rst leave this state.
- Invariants:
  - mem_we is never asserted outside WRITE.
  - mem_addr and mem_wdata hold their last value when mem_we=0.
- Gaps in byte_valid: any number of idle cycles between bytes is legal; state is held.
- start while busy: ignored.
- rst mid-load: immediate return to reset values, with cpu_rst_n=0. Words already written stay in memory, and no partial word is written.
- busy = (state is HDR, DATA or WRITE). CHK also counts as busy when LOADER_CHECKSUM_EN is defined.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the FSM enters state CHK with byte_ready=1.
  - The next accepted byte is compared against the running XOR of the header byte and all data bytes.
  - Match: go to DONE. Mismatch: go to ERROR (the words stay written, but cpu_rst_n stays 0).
  - N=0 also passes through CHK; the expected checksum is the header byte 0x00.
- Not defined: no CHK state, no checksum byte is consumed, and the last WRITE goes directly to DONE.

Test Plan:
- Single word: rst, start, stream 01, 13,05,50,00 with byte_valid held -> one mem_we pulse with mem_addr=0x00, mem_wdata=0x00500513; then done=1, cpu_rst_n=1, word_count=1.
- Three words with 2-cycle gaps between bytes: N=03, words 0x00000093, 0x00100113, 0x002081B3 -> mem_we at addresses 0x00, 0x04, 0x08 with those values; no extra strobes; busy=0 afterwards.
- Oversize: N=0x41 with MAX_WORDS=64 -> error=1, no mem_we, cpu_rst_n=0, byte_ready=0; a subsequent start followed by N=00 -> done=1, cpu_rst_n=1.
- Reset mid-load: N=02, six data bytes, then rst for 1 cycle -> exactly one mem_we (addr 0x00); all outputs at reset values; the following byte_valid is not accepted (byte_ready=0).
- Restart from DONE: after a completed 1-word load, pulse start -> cpu_rst_n=0 next cycle; a new 1-word load of 0xDEADBEEF writes mem_addr=0x00; done=1 again.
- Checksum (LOADER_CHECKSUM_EN defined): N=01, bytes 13,05,50,00, checksum 0x47 -> done=1; the same stream with checksum 0x00 -> error=1, cpu_rst_n=0, and the word is still written once.
